// File: rtl/axi_chan_buffer.sv
// axi_chan_buffer: single-clock AXI4 decoupling buffer across all five channels.
//
// Each channel (AW, W, AR towards the master port; B, R back towards the slave
// port) runs through its own 2**LOG_DEPTH deep FIFO. Every ready and valid
// output comes from registered state, so no combinational path crosses the
// buffer. Payloads are opaque bit vectors and pass through unchanged, in order.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   s_aw_*, s_w_*, s_ar_*     request channels in from upstream (valid/chan in, ready out)
//   s_b_*, s_r_*              response channels out to upstream (valid/chan out, ready in)
//   m_aw_*, m_w_*, m_ar_*     request channels out to downstream
//   m_b_*, m_r_*              response channels in from downstream
module axi_chan_buffer #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 2,
  parameter int unsigned LOG_DEPTH      = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  // Upstream (slave port)
  input  logic                                                       s_aw_valid,
  output logic                                                       s_aw_ready,
  input  logic [AXI_ID_WIDTH+AXI_ADDR_WIDTH+AXI_USER_WIDTH+34:0]     s_aw_chan,
  input  logic                                                       s_w_valid,
  output logic                                                       s_w_ready,
  input  logic [AXI_DATA_WIDTH+AXI_DATA_WIDTH/8+AXI_USER_WIDTH:0]    s_w_chan,
  output logic                                                       s_b_valid,
  input  logic                                                       s_b_ready,
  output logic [AXI_ID_WIDTH+AXI_USER_WIDTH+1:0]                     s_b_chan,
  input  logic                                                       s_ar_valid,
  output logic                                                       s_ar_ready,
  input  logic [AXI_ID_WIDTH+AXI_ADDR_WIDTH+AXI_USER_WIDTH+28:0]     s_ar_chan,
  output logic                                                       s_r_valid,
  input  logic                                                       s_r_ready,
  output logic [AXI_ID_WIDTH+AXI_DATA_WIDTH+AXI_USER_WIDTH+2:0]      s_r_chan,
  // Downstream (master port)
  output logic                                                       m_aw_valid,
  input  logic                                                       m_aw_ready,
  output logic [AXI_ID_WIDTH+AXI_ADDR_WIDTH+AXI_USER_WIDTH+34:0]     m_aw_chan,
  output logic                                                       m_w_valid,
  input  logic                                                       m_w_ready,
  output logic [AXI_DATA_WIDTH+AXI_DATA_WIDTH/8+AXI_USER_WIDTH:0]    m_w_chan,
  input  logic                                                       m_b_valid,
  output logic                                                       m_b_ready,
  input  logic [AXI_ID_WIDTH+AXI_USER_WIDTH+1:0]                     m_b_chan,
  output logic                                                       m_ar_valid,
  input  logic                                                       m_ar_ready,
  output logic [AXI_ID_WIDTH+AXI_ADDR_WIDTH+AXI_USER_WIDTH+28:0]     m_ar_chan,
  input  logic                                                       m_r_valid,
  output logic                                                       m_r_ready,
  input  logic [AXI_ID_WIDTH+AXI_DATA_WIDTH+AXI_USER_WIDTH+2:0]      m_r_chan
);

  localparam int unsigned Depth   = 2 ** LOG_DEPTH;
  localparam int unsigned AwWidth = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_USER_WIDTH + 35;
  localparam int unsigned WWidth  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + AXI_USER_WIDTH + 1;
  localparam int unsigned BWidth  = AXI_ID_WIDTH + AXI_USER_WIDTH + 2;
  localparam int unsigned ArWidth = AwWidth - 6;
  localparam int unsigned RWidth  = AXI_ID_WIDTH + AXI_DATA_WIDTH + AXI_USER_WIDTH + 3;

  localparam logic [LOG_DEPTH-1:0] PtrOne = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   CntOne = (LOG_DEPTH + 1)'(1);

  // Count tops out at exactly 2**LOG_DEPTH, so its MSB alone marks "full".
  // Pointers are LOG_DEPTH bits wide and wrap on their own.

  // ---------------------------------------------------------------- AW
  logic [AwWidth-1:0]   r_aw_mem [Depth];
  logic [LOG_DEPTH-1:0] r_aw_wptr, r_aw_rptr;
  logic [LOG_DEPTH:0]   r_aw_cnt;
  logic                 w_aw_push, w_aw_pop;

  assign s_aw_ready = !r_aw_cnt[LOG_DEPTH] && !rst_i;
  assign m_aw_valid = |r_aw_cnt;
  assign m_aw_chan  = r_aw_mem[r_aw_rptr];
  assign w_aw_push  = s_aw_valid && s_aw_ready;
  assign w_aw_pop   = m_aw_valid && m_aw_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_wptr <= '0;
      r_aw_rptr <= '0;
      r_aw_cnt  <= '0;
    end else begin
      if (w_aw_push) r_aw_wptr <= r_aw_wptr + PtrOne;
      if (w_aw_pop)  r_aw_rptr <= r_aw_rptr + PtrOne;
      r_aw_cnt <= r_aw_cnt + (w_aw_push ? CntOne : '0) - (w_aw_pop ? CntOne : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_aw_push) r_aw_mem[r_aw_wptr] <= s_aw_chan;
  end

  // ---------------------------------------------------------------- W
  logic [WWidth-1:0]    r_w_mem [Depth];
  logic [LOG_DEPTH-1:0] r_w_wptr, r_w_rptr;
  logic [LOG_DEPTH:0]   r_w_cnt;
  logic                 w_w_push, w_w_pop;

  assign s_w_ready = !r_w_cnt[LOG_DEPTH] && !rst_i;
  assign m_w_valid = |r_w_cnt;
  assign m_w_chan  = r_w_mem[r_w_rptr];
  assign w_w_push  = s_w_valid && s_w_ready;
  assign w_w_pop   = m_w_valid && m_w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_w_wptr <= '0;
      r_w_rptr <= '0;
      r_w_cnt  <= '0;
    end else begin
      if (w_w_push) r_w_wptr <= r_w_wptr + PtrOne;
      if (w_w_pop)  r_w_rptr <= r_w_rptr + PtrOne;
      r_w_cnt <= r_w_cnt + (w_w_push ? CntOne : '0) - (w_w_pop ? CntOne : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_push) r_w_mem[r_w_wptr] <= s_w_chan;
  end

  // ---------------------------------------------------------------- AR
  logic [ArWidth-1:0]   r_ar_mem [Depth];
  logic [LOG_DEPTH-1:0] r_ar_wptr, r_ar_rptr;
  logic [LOG_DEPTH:0]   r_ar_cnt;
  logic                 w_ar_push, w_ar_pop;

  assign s_ar_ready = !r_ar_cnt[LOG_DEPTH] && !rst_i;
  assign m_ar_valid = |r_ar_cnt;
  assign m_ar_chan  = r_ar_mem[r_ar_rptr];
  assign w_ar_push  = s_ar_valid && s_ar_ready;
  assign w_ar_pop   = m_ar_valid && m_ar_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ar_wptr <= '0;
      r_ar_rptr <= '0;
      r_ar_cnt  <= '0;
    end else begin
      if (w_ar_push) r_ar_wptr <= r_ar_wptr + PtrOne;
      if (w_ar_pop)  r_ar_rptr <= r_ar_rptr + PtrOne;
      r_ar_cnt <= r_ar_cnt + (w_ar_push ? CntOne : '0) - (w_ar_pop ? CntOne : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_ar_push) r_ar_mem[r_ar_wptr] <= s_ar_chan;
  end

  // ---------------------------------------------------------------- B (master -> slave)
  logic [BWidth-1:0]    r_b_mem [Depth];
  logic [LOG_DEPTH-1:0] r_b_wptr, r_b_rptr;
  logic [LOG_DEPTH:0]   r_b_cnt;
  logic                 w_b_push, w_b_pop;

  assign m_b_ready = !r_b_cnt[LOG_DEPTH] && !rst_i;
  assign s_b_valid = |r_b_cnt;
  assign s_b_chan  = r_b_mem[r_b_rptr];
  assign w_b_push  = m_b_valid && m_b_ready;
  assign w_b_pop   = s_b_valid && s_b_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_b_wptr <= '0;
      r_b_rptr <= '0;
      r_b_cnt  <= '0;
    end else begin
      if (w_b_push) r_b_wptr <= r_b_wptr + PtrOne;
      if (w_b_pop)  r_b_rptr <= r_b_rptr + PtrOne;
      r_b_cnt <= r_b_cnt + (w_b_push ? CntOne : '0) - (w_b_pop ? CntOne : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_b_push) r_b_mem[r_b_wptr] <= m_b_chan;
  end

  // ---------------------------------------------------------------- R (master -> slave)
  logic [RWidth-1:0]    r_r_mem [Depth];
  logic [LOG_DEPTH-1:0] r_r_wptr, r_r_rptr;
  logic [LOG_DEPTH:0]   r_r_cnt;
  logic                 w_r_push, w_r_pop;

  assign m_r_ready = !r_r_cnt[LOG_DEPTH] && !rst_i;
  assign s_r_valid = |r_r_cnt;
  assign s_r_chan  = r_r_mem[r_r_rptr];
  assign w_r_push  = m_r_valid && m_r_ready;
  assign w_r_pop   = s_r_valid && s_r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_r_wptr <= '0;
      r_r_rptr <= '0;
      r_r_cnt  <= '0;
    end else begin
      if (w_r_push) r_r_wptr <= r_r_wptr + PtrOne;
      if (w_r_pop)  r_r_rptr <= r_r_rptr + PtrOne;
      r_r_cnt <= r_r_cnt + (w_r_push ? CntOne : '0) - (w_r_pop ? CntOne : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_r_push) r_r_mem[r_r_wptr] <= m_r_chan;
  end

endmodule

// File: tb/tb_axi_chan_buffer.sv
// tb_axi_chan_buffer: self-checking bench for axi_chan_buffer.
// Channels are handled generically by index: 0=AW, 1=W, 2=AR, 3=B, 4=R.
// "src" is the side that pushes into the buffer, "dst" the side that drains it.
// The reference model is a per-channel in-order scoreboard: whatever the
// source side handed over must come out of the destination side unchanged.
module tb_axi_chan_buffer;

  localparam int unsigned IdW      = 4;
  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 64;
  localparam int unsigned UserW    = 2;
  localparam int unsigned LogDepth = 2;
  localparam int unsigned Depth    = 2 ** LogDepth;
  localparam int unsigned AwW      = IdW + AddrW + UserW + 35;
  localparam int unsigned WW       = DataW + DataW / 8 + 1 + UserW;
  localparam int unsigned ArW      = AwW - 6;
  localparam int unsigned BW       = IdW + 2 + UserW;
  localparam int unsigned RW       = IdW + DataW + 3 + UserW;
  localparam int unsigned MW       = 80;
  localparam int unsigned SbSize   = 9000;
  localparam int          Budget   = 2000;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic          src_valid [5];
  logic          src_ready [5];
  logic [MW-1:0] src_chan  [5];
  logic          dst_valid [5];
  logic          dst_ready [5];
  logic [MW-1:0] dst_chan  [5];

  logic [AwW-1:0] m_aw_chan;
  logic [WW-1:0]  m_w_chan;
  logic [ArW-1:0] m_ar_chan;
  logic [BW-1:0]  s_b_chan;
  logic [RW-1:0]  s_r_chan;

  assign dst_chan[0] = MW'(m_aw_chan);
  assign dst_chan[1] = MW'(m_w_chan);
  assign dst_chan[2] = MW'(m_ar_chan);
  assign dst_chan[3] = MW'(s_b_chan);
  assign dst_chan[4] = MW'(s_r_chan);

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] sb_mem [5][SbSize];
  int            sb_wr  [5];
  int            sb_rd  [5];

  axi_chan_buffer #(
    .AXI_ADDR_WIDTH (AddrW),
    .AXI_DATA_WIDTH (DataW),
    .AXI_ID_WIDTH   (IdW),
    .AXI_USER_WIDTH (UserW),
    .LOG_DEPTH      (LogDepth)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_aw_valid (src_valid[0]),
    .s_aw_ready (src_ready[0]),
    .s_aw_chan  (src_chan[0][AwW-1:0]),
    .s_w_valid  (src_valid[1]),
    .s_w_ready  (src_ready[1]),
    .s_w_chan   (src_chan[1][WW-1:0]),
    .s_b_valid  (dst_valid[3]),
    .s_b_ready  (dst_ready[3]),
    .s_b_chan   (s_b_chan),
    .s_ar_valid (src_valid[2]),
    .s_ar_ready (src_ready[2]),
    .s_ar_chan  (src_chan[2][ArW-1:0]),
    .s_r_valid  (dst_valid[4]),
    .s_r_ready  (dst_ready[4]),
    .s_r_chan   (s_r_chan),
    .m_aw_valid (dst_valid[0]),
    .m_aw_ready (dst_ready[0]),
    .m_aw_chan  (m_aw_chan),
    .m_w_valid  (dst_valid[1]),
    .m_w_ready  (dst_ready[1]),
    .m_w_chan   (m_w_chan),
    .m_b_valid  (src_valid[3]),
    .m_b_ready  (src_ready[3]),
    .m_b_chan   (src_chan[3][BW-1:0]),
    .m_ar_valid (dst_valid[2]),
    .m_ar_ready (dst_ready[2]),
    .m_ar_chan  (m_ar_chan),
    .m_r_valid  (src_valid[4]),
    .m_r_ready  (src_ready[4]),
    .m_r_chan   (src_chan[4][RW-1:0])
  );

  function automatic int chan_width(input int c);
    case (c)
      0:       return AwW;
      1:       return WW;
      2:       return ArW;
      3:       return BW;
      default: return RW;
    endcase
  endfunction

  function automatic logic [MW-1:0] rand_payload(input int c);
    logic [MW-1:0] ones;
    logic [MW-1:0] r;
    ones = '1;
    r    = MW'({$urandom(), $urandom(), $urandom()});
    return r & (ones >> (MW - chan_width(c)));
  endfunction

  // Half the time no gap, otherwise 1..max_gap idle cycles.
  function automatic int rand_gap(input int max_gap);
    if (max_gap == 0) return 0;
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, max_gap));
  endfunction

  // Source-side driver: presents n random beats, records each accepted beat.
  task automatic drive(input int c, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int            waited;
      logic [MW-1:0] p;
      repeat (rand_gap(max_gap)) begin
        @(posedge clk_i);
        #1;
      end
      p            = rand_payload(c);
      src_chan[c]  = p;
      src_valid[c] = 1'b1;
      waited       = 0;
      @(negedge clk_i);
      while (!src_ready[c]) begin
        waited++;
        if (waited > Budget) begin
          checks++;
          errors++;
          $display("FAIL drive_timeout ch%0d beat %0d: ready=0 required=1", c, i);
          src_valid[c] = 1'b0;
          return;
        end
        @(negedge clk_i);
      end
      sb_mem[c][sb_wr[c]] = p;
      sb_wr[c]++;
      @(posedge clk_i);
      #1;
      src_valid[c] = 1'b0;
    end
  endtask

  // Destination-side sink: takes n beats and checks them against the scoreboard.
  task automatic sink(input int c, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int waited;
      repeat (rand_gap(max_gap)) begin
        @(posedge clk_i);
        #1;
      end
      dst_ready[c] = 1'b1;
      waited       = 0;
      @(negedge clk_i);
      while (!dst_valid[c]) begin
        waited++;
        if (waited > Budget) begin
          checks++;
          errors++;
          $display("FAIL sink_timeout ch%0d beat %0d: valid=0 required=1", c, i);
          dst_ready[c] = 1'b0;
          return;
        end
        @(negedge clk_i);
      end
      checks++;
      if (sb_rd[c] >= sb_wr[c] || dst_chan[c] !== sb_mem[c][sb_rd[c]]) begin
        errors++;
        $display("FAIL sink_data ch%0d beat %0d: got %h required %h (sent %0d taken %0d)",
                 c, i, dst_chan[c], sb_mem[c][sb_rd[c]], sb_wr[c], sb_rd[c]);
      end
      sb_rd[c]++;
      @(posedge clk_i);
      #1;
      dst_ready[c] = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (src_ready[c] !== 1'b0 || dst_valid[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs ch%0d: ready=%b valid=%b required 0/0",
                 c, src_ready[c], dst_valid[c]);
      end
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (src_ready[c] !== 1'b1 || dst_valid[c] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset ch%0d: ready=%b valid=%b required 1/0",
                 c, src_ready[c], dst_valid[c]);
      end
    end
    // Buffer three AW beats with the master side stalled, then reset mid-cycle.
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 3; k++) begin
      src_chan[0]  = rand_payload(0);
      src_valid[0] = 1'b1;
      @(posedge clk_i);
      #1;
    end
    src_valid[0] = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dst_valid[0] !== 1'b1 || src_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_fill: valid=%b ready=%b required 1/1", dst_valid[0], src_ready[0]);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (dst_valid[0] !== 1'b0 || src_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b ready=%b required 0/0", dst_valid[0], src_ready[0]);
    end
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    dst_ready[0] = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      checks++;
      if (src_ready[0] !== 1'b1 || dst_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush: ready=%b valid=%b required 1/0", src_ready[0], dst_valid[0]);
      end
    end
    @(posedge clk_i);
    #1;
    dst_ready[0] = 1'b0;
  endtask

  task automatic test_single_write();
    logic [AwW-1:0] aw;
    logic [WW-1:0]  w;
    logic [BW-1:0]  b;
    aw = {4'd3, 32'h0000_1000, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 2'd0};
    w  = {64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 2'd0};
    b  = {4'd3, 2'b00, 2'd0};
    src_chan[0]  = MW'(aw);
    src_chan[1]  = MW'(w);
    src_valid[0] = 1'b1;
    src_valid[1] = 1'b1;
    @(negedge clk_i);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (src_ready[c] !== 1'b1 || dst_valid[c] !== 1'b0) begin
        errors++;
        $display("FAIL write_no_bypass ch%0d: ready=%b valid=%b required 1/0",
                 c, src_ready[c], dst_valid[c]);
      end
    end
    @(posedge clk_i);
    #1;
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    dst_ready[0] = 1'b1;
    dst_ready[1] = 1'b1;
    @(negedge clk_i);
    checks++;
    if (dst_valid[0] !== 1'b1 || dst_chan[0] !== MW'(aw)) begin
      errors++;
      $display("FAIL write_aw: valid=%b chan=%h required 1/%h", dst_valid[0], dst_chan[0], aw);
    end
    checks++;
    if (dst_valid[1] !== 1'b1 || dst_chan[1] !== MW'(w)) begin
      errors++;
      $display("FAIL write_w: valid=%b chan=%h required 1/%h", dst_valid[1], dst_chan[1], w);
    end
    @(posedge clk_i);
    #1;
    dst_ready[0] = 1'b0;
    dst_ready[1] = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dst_valid[0] !== 1'b0 || dst_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_drained: aw_valid=%b w_valid=%b required 0/0",
               dst_valid[0], dst_valid[1]);
    end
    // Response from the downstream slave.
    @(posedge clk_i);
    #1;
    src_chan[3]  = MW'(b);
    src_valid[3] = 1'b1;
    dst_ready[3] = 1'b1;
    @(negedge clk_i);
    checks++;
    if (src_ready[3] !== 1'b1 || dst_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL b_no_bypass: ready=%b valid=%b required 1/0", src_ready[3], dst_valid[3]);
    end
    @(posedge clk_i);
    #1;
    src_valid[3] = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dst_valid[3] !== 1'b1 || dst_chan[3] !== MW'(b)) begin
      errors++;
      $display("FAIL b_resp: valid=%b chan=%h required 1/%h", dst_valid[3], dst_chan[3], b);
    end
    @(posedge clk_i);
    #1;
    dst_ready[3] = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dst_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL b_drained: valid=%b required 0", dst_valid[3]);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_fill_backpressure();
    logic [MW-1:0] ar [Depth+1];
    int            popped;
    int            cyc;
    bit            accepted;
    for (int k = 0; k <= Depth; k++) ar[k] = rand_payload(2);
    dst_ready[2] = 1'b0;
    for (int k = 0; k < Depth; k++) begin
      src_chan[2]  = ar[k];
      src_valid[2] = 1'b1;
      @(negedge clk_i);
      checks++;
      if (src_ready[2] !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready beat %0d: ready=%b required 1", k, src_ready[2]);
      end
      @(posedge clk_i);
      #1;
    end
    src_chan[2] = ar[Depth];
    repeat (2) begin
      @(negedge clk_i);
      checks++;
      if (src_ready[2] !== 1'b0 || dst_valid[2] !== 1'b1) begin
        errors++;
        $display("FAIL full_stall: ready=%b valid=%b required 0/1", src_ready[2], dst_valid[2]);
      end
      @(posedge clk_i);
      #1;
    end
    dst_ready[2] = 1'b1;
    @(negedge clk_i);
    checks++;
    if (src_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL full_no_passthrough: ready=%b required 0", src_ready[2]);
    end
    popped   = 0;
    cyc      = 0;
    accepted = 1'b0;
    while (popped < Depth + 1 && cyc < 20) begin
      if (dst_valid[2]) begin
        checks++;
        if (dst_chan[2] !== ar[popped]) begin
          errors++;
          $display("FAIL fill_order beat %0d: got %h required %h", popped, dst_chan[2], ar[popped]);
        end
        popped++;
      end
      if (src_valid[2] && src_ready[2]) accepted = 1'b1;
      @(posedge clk_i);
      #1;
      if (accepted) src_valid[2] = 1'b0;
      cyc++;
      @(negedge clk_i);
    end
    checks++;
    if (popped != Depth + 1 || !accepted) begin
      errors++;
      $display("FAIL fill_drain: popped=%0d accepted=%0d required %0d/1", popped, accepted,
               Depth + 1);
    end
    @(posedge clk_i);
    #1;
    src_valid[2] = 1'b0;
    dst_ready[2] = 1'b0;
  endtask

  task automatic test_burst_r();
    logic [MW-1:0] beats [16];
    for (int k = 0; k < 16; k++) begin
      logic [RW-1:0] r;
      r        = {4'd5, $urandom(), $urandom(), 2'b00, (k == 15) ? 1'b1 : 1'b0, 2'b01};
      beats[k] = MW'(r);
    end
    dst_ready[4] = 1'b1;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          src_chan[4]  = beats[k];
          src_valid[4] = 1'b1;
          @(negedge clk_i);
          checks++;
          if (src_ready[4] !== 1'b1) begin
            errors++;
            $display("FAIL burst_src_ready beat %0d: ready=%b required 1", k, src_ready[4]);
          end
          @(posedge clk_i);
          #1;
        end
        src_valid[4] = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk_i);
        while (!dst_valid[4] && w < 10) begin
          w++;
          @(negedge clk_i);
        end
        for (int k = 0; k < 16; k++) begin
          checks++;
          if (dst_valid[4] !== 1'b1 || dst_chan[4] !== beats[k] ||
              dst_chan[4][UserW] !== ((k == 15) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL burst_beat %0d: valid=%b chan=%h required 1/%h", k, dst_valid[4],
                     dst_chan[4], beats[k]);
          end
          @(negedge clk_i);
        end
        checks++;
        if (dst_valid[4] !== 1'b0) begin
          errors++;
          $display("FAIL burst_end: valid=%b required 0", dst_valid[4]);
        end
      end
    join
    @(posedge clk_i);
    #1;
    dst_ready[4] = 1'b0;
  endtask

  task automatic test_independence();
    dst_ready[1] = 1'b0;
    drive(1, Depth, 0);
    fork
      drive(2, 12, 3);
      sink(2, 12, 3);
      drive(4, 12, 3);
      sink(4, 12, 3);
    join
    @(negedge clk_i);
    checks++;
    if (src_ready[1] !== 1'b0 || dst_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL indep_w_stalled: ready=%b valid=%b required 0/1", src_ready[1], dst_valid[1]);
    end
    for (int c = 2; c <= 4; c += 2) begin
      checks++;
      if (sb_rd[c] != sb_wr[c]) begin
        errors++;
        $display("FAIL indep_flow ch%0d: taken=%0d required %0d", c, sb_rd[c], sb_wr[c]);
      end
    end
    @(posedge clk_i);
    #1;
    sink(1, Depth, 0);
  endtask

  task automatic test_random_soak();
    int n_wbeats;
    int n_rbeats;
    int target [5];
    n_wbeats = 0;
    n_rbeats = 0;
    for (int i = 0; i < 500; i++) begin
      n_wbeats += int'($urandom_range(1, 16));
      n_rbeats += int'($urandom_range(1, 16));
    end
    target[0] = sb_wr[0] + 500;
    target[1] = sb_wr[1] + n_wbeats;
    target[2] = sb_wr[2] + 500;
    target[3] = sb_wr[3] + 500;
    target[4] = sb_wr[4] + n_rbeats;
    fork
      drive(0, 500, 10);
      sink(0, 500, 10);
      drive(1, n_wbeats, 10);
      sink(1, n_wbeats, 10);
      drive(2, 500, 10);
      sink(2, 500, 10);
      drive(3, 500, 10);
      sink(3, 500, 10);
      drive(4, n_rbeats, 10);
      sink(4, n_rbeats, 10);
    join
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (sb_wr[c] != target[c] || sb_rd[c] != target[c]) begin
        errors++;
        $display("FAIL soak_complete ch%0d: sent=%0d taken=%0d required %0d",
                 c, sb_wr[c], sb_rd[c], target[c]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      src_valid[c] = 1'b0;
      dst_ready[c] = 1'b0;
      src_chan[c]  = '0;
      sb_wr[c]     = 0;
      sb_rd[c]     = 0;
    end
    test_reset();
    test_single_write();
    test_fill_backpressure();
    test_burst_r();
    test_independence();
    test_random_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
